// File: rtl/micro_div_seq_njp.sv
// Sequential restoring divider: one quotient bit per clock, unsigned operands.
// Control FSM and registered results in one block; the working datapath sits in a second block with no reset.
module micro_div_seq_njp #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] r_reg;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] r_next;

   // A borrow out of the (WIDTH+1)-bit subtraction means trial < divisor.
   always_comb begin
      trial  = {r_reg, q_reg[WIDTH-1]};
      diff   = trial - {1'b0, d_reg};
      ge     = ~diff[WIDTH];
      q_next = {q_reg[WIDTH-2:0], ge};
      r_next = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         dbz       <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         cnt       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (divisor == '0) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     dbz       <= 1'b1;
                     done      <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     cnt   <= '0;
                     dbz   <= 1'b0;
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  quotient  <= q_next;
                  remainder <= r_next;
                  done      <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Working registers load on an accepted non-zero-divisor start and shift during RUN.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && start && divisor != '0) begin
         d_reg <= divisor;
         q_reg <= dividend;
         r_reg <= '0;
      end else if (state == S_RUN) begin
         q_reg <= q_next;
         r_reg <= r_next;
      end
   end

endmodule
